// File: rtl/pipe_skid_reg_pkg.sv
// Shared pipeline package: default payload widths and skid-register state
// encodings used by every stage register in the core.
package pipe_skid_reg_pkg;

  localparam int DATA_W_D = 32;
  localparam int CTRL_W_D = 2;
  localparam int ADDR_W_D = 5;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } skid_st_e;

endpackage

// File: rtl/pipe_entry.sv
// One payload slot of a skid register: load enable plus synchronous clear,
// clear wins over load.
module pipe_entry #(
  parameter int W = 39
) (
  input  logic         clk_i,
  input  logic         start_i,
  input  logic         clr_i,
  input  logic         ld_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      r_q <= '0;
    end else if (clr_i) begin
      r_q <= '0;
    end else if (ld_i) begin
      r_q <= d_i;
    end
  end

  assign q_o = r_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid stage register: full throughput, ready_o purely registered,
// payload zeroed whenever the stage holds a bubble.
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int DATA_W = DATA_W_D,
  parameter int CTRL_W = CTRL_W_D,
  parameter int ADDR_W = ADDR_W_D
) (
  input  logic              clk_i,
  input  logic              start_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [1:0]        count_o
);

  localparam int PW = CTRL_W + ADDR_W + DATA_W;

  skid_st_e        r_state;
  skid_st_e        w_nxt;
  logic [PW-1:0]   w_in;
  logic [PW-1:0]   w_main_d;
  logic [PW-1:0]   w_main_q;
  logic [PW-1:0]   w_skid_q;
  logic            w_ld_main;
  logic            w_clr_main;
  logic            w_ld_skid;
  logic            w_clr_skid;

  assign w_in = {ctrl_i, addr_i, data_i};

  always_comb begin
    w_nxt      = r_state;
    w_ld_main  = 1'b0;
    w_clr_main = 1'b0;
    w_ld_skid  = 1'b0;
    w_clr_skid = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (valid_i) begin
          w_ld_main = 1'b1;
          w_nxt     = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (valid_i && ready_i) begin
          w_ld_main = 1'b1;
        end else if (valid_i) begin
          w_ld_skid = 1'b1;
          w_nxt     = ST_FULL;
        end else if (ready_i) begin
          w_clr_main = 1'b1;
          w_nxt      = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (ready_i) begin
          w_ld_main  = 1'b1;
          w_clr_skid = 1'b1;
          w_nxt      = ST_BUSY;
        end
      end
      default: begin
        w_clr_main = 1'b1;
        w_clr_skid = 1'b1;
        w_nxt      = ST_EMPTY;
      end
    endcase
    // Flush overrides everything, including an input offered this cycle.
    if (flush_i) begin
      w_ld_main  = 1'b0;
      w_ld_skid  = 1'b0;
      w_clr_main = 1'b1;
      w_clr_skid = 1'b1;
      w_nxt      = ST_EMPTY;
    end
  end

  assign w_main_d = (r_state == ST_FULL) ? w_skid_q : w_in;

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_nxt;
    end
  end

  pipe_entry #(.W(PW)) u_main (
    .clk_i   (clk_i),
    .start_i (start_i),
    .clr_i   (w_clr_main),
    .ld_i    (w_ld_main),
    .d_i     (w_main_d),
    .q_o     (w_main_q)
  );

  pipe_entry #(.W(PW)) u_skid (
    .clk_i   (clk_i),
    .start_i (start_i),
    .clr_i   (w_clr_skid),
    .ld_i    (w_ld_skid),
    .d_i     (w_in),
    .q_o     (w_skid_q)
  );

  assign {ctrl_o, addr_o, data_o} = w_main_q;
  assign ready_o = (r_state != ST_FULL);
  assign valid_o = (r_state != ST_EMPTY);
  assign count_o = r_state;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg plus a short random scoreboard run.
module tb_pipe_skid_reg;

  logic        clk = 1'b0;
  logic        start_i;
  logic        flush_i;
  logic        valid_i;
  logic        ready_o;
  logic [1:0]  ctrl_i;
  logic [31:0] data_i;
  logic [4:0]  addr_i;
  logic        valid_o;
  logic        ready_i;
  logic [1:0]  ctrl_o;
  logic [31:0] data_o;
  logic [4:0]  addr_o;
  logic [1:0]  count_o;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_skid_reg dut (
    .clk_i   (clk),
    .start_i (start_i),
    .flush_i (flush_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .ctrl_i  (ctrl_i),
    .data_i  (data_i),
    .addr_i  (addr_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .ctrl_o  (ctrl_o),
    .data_o  (data_o),
    .addr_o  (addr_o),
    .count_o (count_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic v, input logic r, input logic [1:0] c,
                      input logic [31:0] d);
    valid_i = v;
    ready_i = r;
    ctrl_i  = c;
    data_i  = d;
    addr_i  = d[4:0];
  endtask

  logic [38:0] q[$];
  logic [38:0] w_pay;
  logic [38:0] w_exp;
  logic        in_f;
  logic        out_f;

  initial begin
    start_i = 1'b0;
    flush_i = 1'b0;
    push(0, 0, 2'b00, 32'h0);
    #2;
    chk("rst_valid", valid_o, 0);
    chk("rst_ready", ready_o, 1);
    chk("rst_count", count_o, 0);
    chk("rst_data",  data_o, 0);
    chk("rst_ctrl",  ctrl_o, 0);
    @(negedge clk);
    start_i = 1'b1;

    push(1, 1, 2'b01, 32'd1);
    cyc();
    chk("strm_d1", data_o, 1);
    chk("strm_c1", count_o, 1);
    push(1, 1, 2'b01, 32'd2);
    cyc();
    chk("strm_d2", data_o, 2);
    chk("strm_c2", count_o, 1);
    push(1, 1, 2'b01, 32'd3);
    cyc();
    chk("strm_d3", data_o, 3);
    chk("strm_c3", count_o, 1);
    push(0, 1, 2'b00, 32'd0);
    cyc();
    chk("drain_cnt", count_o, 0);
    chk("drain_data", data_o, 0);

    push(1, 1, 2'b11, 32'hA);
    cyc();
    chk("bp_busy", data_o, 32'hA);
    push(1, 0, 2'b11, 32'hB);
    cyc();
    chk("bp_cnt", count_o, 2);
    chk("bp_rdy", ready_o, 0);
    chk("bp_hold", data_o, 32'hA);
    push(1, 0, 2'b11, 32'hD);
    cyc();
    chk("full_ign_cnt", count_o, 2);
    chk("full_ign_dat", data_o, 32'hA);
    push(0, 1, 2'b00, 32'h0);
    cyc();
    chk("bp_second", data_o, 32'hB);
    chk("bp_cnt1", count_o, 1);
    cyc();
    chk("bp_empty", count_o, 0);

    push(1, 1, 2'b11, 32'h11);
    cyc();
    push(1, 0, 2'b11, 32'h22);
    cyc();
    chk("fl_full", count_o, 2);
    push(1, 1, 2'b11, 32'hC);
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    chk("fl_cnt", count_o, 0);
    chk("fl_ctrl", ctrl_o, 0);
    chk("fl_data", data_o, 0);
    chk("fl_rdy", ready_o, 1);
    push(0, 1, 2'b00, 32'h0);
    cyc();
    chk("fl_noC", {valid_o, data_o}, 0);

    push(1, 0, 2'b11, 32'h5);
    cyc();
    chk("bub_ctrl_in", ctrl_o, 2'b11);
    push(0, 1, 2'b00, 32'h0);
    cyc();
    chk("bub_valid", valid_o, 0);
    chk("bub_ctrl", ctrl_o, 2'b00);
    cyc();
    chk("empty_rdy_i", count_o, 0);

    push(1, 0, 2'b10, 32'h31);
    cyc();
    push(1, 0, 2'b10, 32'h32);
    cyc();
    chk("rr_full", count_o, 2);
    start_i = 1'b0;
    #1;
    chk("rr_valid", valid_o, 0);
    chk("rr_ready", ready_o, 1);
    chk("rr_count", count_o, 0);
    chk("rr_data", data_o, 0);
    @(negedge clk);
    start_i = 1'b1;
    push(1, 1, 2'b01, 32'h77);
    cyc();
    chk("rr_first", data_o, 32'h77);
    chk("rr_cnt", count_o, 1);
    push(0, 1, 2'b00, 32'h0);
    cyc();
    chk("rr_drain", count_o, 0);

    q.delete();
    for (int i = 0; i < 2000; i++) begin
      push(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           2'($urandom), $urandom);
      w_pay = {ctrl_i, addr_i, data_i};
      in_f  = valid_i && (q.size() != 2);
      out_f = ready_i && (q.size() != 0);
      cyc();
      if (out_f) void'(q.pop_front());
      if (in_f) q.push_back(w_pay);
      w_exp = (q.size() != 0) ? q[0] : '0;
      chk("rnd_cnt", count_o, 64'(q.size()));
      chk("rnd_rdy", ready_o, (q.size() != 2));
      chk("rnd_pay", {ctrl_o, addr_o, data_o}, w_exp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
